// File: rtl/lshift_seq_if.sv
// Start/done handshake bundle for the sequential left-shift unit.
// master drives the request; slave returns status and result.
interface lshift_seq_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
);
    logic             start;
    logic [WIDTH-1:0] in;
    logic [CNT_W-1:0] amt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             ovf;

    modport master (
        output start, in, amt,
        input  busy, done, out, ovf
    );

    modport slave (
        input  start, in, amt,
        output busy, done, out, ovf
    );
endinterface

// File: rtl/lshift_seq.sv
// Sequential left shifter: out = in << amt, one bit per clock.
// ovf records any 1 bit pushed past the MSB during the run.
module lshift_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    lshift_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] out_q;
    logic [CNT_W-1:0] cnt;
    logic             ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (bus.start) nxt = SHIFT;
            SHIFT:   if (cnt == '0) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Amounts >= WIDTH are not clamped; the counter just runs them out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        out_q <= bus.in;
                        cnt   <= bus.amt;
                        ovf_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        out_q <= {out_q[WIDTH-2:0], 1'b0};
                        ovf_q <= ovf_q | out_q[WIDTH-1];
                        cnt   <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
        bus.out  = out_q;
        bus.ovf  = ovf_q;
    end
endmodule

// File: tb/tb_lshift_seq.sv
// Directed bench for lshift_seq: vector table plus
// reset, start-while-busy and back-to-back sequences.
module tb_lshift_seq;
    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    lshift_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    lshift_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] in;
        logic [CNT_W-1:0] amt;
        logic [WIDTH-1:0] exp_out;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one start, then checks latency, busy span, result and flag.
    task automatic run_op(input vec_t v, input string tag);
        int n;
        int nbusy;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = v.in;
        bus.amt   = v.amt;
        @(posedge clk);
        #1;
        nbusy = bus.busy ? 1 : 0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in    = $urandom;
        bus.amt   = CNT_W'($urandom);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.busy) nbusy++;
            if (bus.done) break;
        end
        check({tag, " latency"}, n, int'(v.amt) + 1);
        check({tag, " busy span"}, nbusy, int'(v.amt) + 2);
        check({tag, " out"}, bus.out, v.exp_out);
        check({tag, " ovf"}, {31'd0, bus.ovf}, {31'd0, v.exp_ovf});
        @(posedge clk);
        #1;
        check({tag, " done drops"}, {31'd0, bus.done}, 32'd0);
        check({tag, " idle"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " out holds"}, bus.out, v.exp_out);
    endtask

    initial begin
        int ndone;
        int last;
        vec_t v;
        tests = 0;
        fails = 0;

        vecs[0] = '{32'h0000_0003, 6'd4,  32'h0000_0030, 1'b0};
        vecs[1] = '{32'hDEAD_BEEF, 6'd0,  32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{32'hC000_0001, 6'd1,  32'h8000_0002, 1'b1};
        vecs[3] = '{32'h8000_0000, 6'd32, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'h0000_0000, 6'd40, 32'h0000_0000, 1'b0};
        vecs[5] = '{32'h0000_0001, 6'd31, 32'h8000_0000, 1'b0};
        vecs[6] = '{32'h0000_0003, 6'd31, 32'h8000_0000, 1'b1};
        vecs[7] = '{32'hFFFF_FFFF, 6'd63, 32'h0000_0000, 1'b1};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.in    = '0;
        bus.amt   = '0;
        #2;
        check("reset out", bus.out, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset ovf", {31'd0, bus.ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset in the middle of a long shift.
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = 32'h1;
        bus.amt   = 6'd20;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst out", bus.out, 32'd0);
        check("midrst busy", {31'd0, bus.busy}, 32'd0);
        check("midrst done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        v = '{32'h3, 6'd2, 32'hC, 1'b0};
        run_op(v, "postrst");

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // A start pulse during SHIFT must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = 32'h1;
        bus.amt   = 6'd8;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.in    = 32'hFF;
        bus.amt   = 6'd1;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                check("busystart out", bus.out, 32'h100);
            end
        end
        check("busystart done count", ndone, 1);
        check("busystart hold", bus.out, 32'h100);

        // Continuous start: one result every six cycles.
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = 32'h5;
        bus.amt   = 6'd3;
        ndone = 0;
        last  = -1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                check("b2b out", bus.out, 32'h28);
                if (last >= 0) check("b2b period", c - last, 6);
                last = c;
            end
        end
        check("b2b done count", ndone, 5);
        @(negedge clk);
        bus.start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
